// File: rtl/mul_wb_unit.sv
// Iterative signed shift-add multiplier that writes its product back to the register file.
// Define MUL_HI_WB_EN to add a second writeback of the high product word to HI_REG.
module mul_wb_unit #(
    parameter int WIDTH = 32,
    parameter int ADDR_W = 5,
    parameter logic [ADDR_W-1:0] HI_REG = ADDR_W'(13)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              flush,
    input  logic [WIDTH-1:0]  opA,
    input  logic [WIDTH-1:0]  opB,
    input  logic [ADDR_W-1:0] destAddr,
    output logic              busy,
    output logic              done,
    output logic              wbEn,
    output logic [ADDR_W-1:0] wbAddr,
    output logic [WIDTH-1:0]  wbData
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

`ifdef MUL_HI_WB_EN
    typedef enum logic [1:0] {IDLE, RUN, WB_LO, WB_HI} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN, WB_LO} state_t;
`endif

    state_t              state;
    logic [WIDTH-1:0]    mcand;
    logic [WIDTH-1:0]    mplier;
    logic [WIDTH-1:0]    acc;
    logic [CNT_W-1:0]    count;
    logic                sign;
    logic [ADDR_W-1:0]   dest;

    logic [WIDTH-1:0]    absA;
    logic [WIDTH-1:0]    absB;
    logic [WIDTH-1:0]    addend;
    logic [WIDTH:0]      sum;
    logic [WIDTH-1:0]    nextAcc;
    logic [WIDTH-1:0]    nextMplier;
    logic [2*WIDTH-1:0]  magProd;
    logic [2*WIDTH-1:0]  finalProd;
    logic                lastStep;

    // The most negative operand negates to itself, which read as unsigned is its true magnitude.
    assign absA = opA[WIDTH-1] ? (~opA + 1'b1) : opA;
    assign absB = opB[WIDTH-1] ? (~opB + 1'b1) : opB;

    // The carry out of the add becomes the top bit after the right shift.
    assign addend     = mplier[0] ? mcand : '0;
    assign sum        = {1'b0, acc} + {1'b0, addend};
    assign nextAcc    = sum[WIDTH:1];
    assign nextMplier = {sum[0], mplier[WIDTH-1:1]};
    assign magProd    = {nextAcc, nextMplier};
    assign finalProd  = sign ? (~magProd + 1'b1) : magProd;
    assign lastStep   = (count == CNT_W'(WIDTH - 1));

    assign busy = (state != IDLE);

    // The final step registers the signed product both into the writeback port and back
    // into {acc, mplier}, so a later high-word writeback can read it from acc.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            sign   <= 1'b0;
            dest   <= '0;
            done   <= 1'b0;
            wbEn   <= 1'b0;
            wbAddr <= '0;
            wbData <= '0;
        end else begin
            wbEn <= 1'b0;
            done <= 1'b0;
            if (flush) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            mcand  <= absA;
                            mplier <= absB;
                            sign   <= opA[WIDTH-1] ^ opB[WIDTH-1];
                            dest   <= destAddr;
                            acc    <= '0;
                            count  <= '0;
                            state  <= RUN;
                        end
                    end
                    RUN: begin
                        if (lastStep) begin
                            {acc, mplier} <= finalProd;
                            state         <= WB_LO;
                            if (dest != '0) begin
                                wbEn   <= 1'b1;
                                wbAddr <= dest;
                                wbData <= finalProd[WIDTH-1:0];
                            end
`ifndef MUL_HI_WB_EN
                            done <= 1'b1;
`endif
                        end else begin
                            acc    <= nextAcc;
                            mplier <= nextMplier;
                            count  <= count + 1'b1;
                        end
                    end
`ifdef MUL_HI_WB_EN
                    WB_LO: begin
                        state  <= WB_HI;
                        wbEn   <= 1'b1;
                        wbAddr <= HI_REG;
                        wbData <= acc;
                        done   <= 1'b1;
                    end
                    WB_HI: begin
                        state <= IDLE;
                    end
`else
                    WB_LO: begin
                        state <= IDLE;
                    end
`endif
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mul_wb_unit.sv
// Directed self-checking bench for mul_wb_unit; honours MUL_HI_WB_EN when defined.
module tb_mul_wb_unit;

`ifdef MUL_HI_WB_EN
    localparam bit HI_EN = 1'b1;
`else
    localparam bit HI_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] opA = '0;
    logic [31:0] opB = '0;
    logic [4:0]  destAddr = '0;
    logic        busy;
    logic        done;
    logic        wbEn;
    logic [4:0]  wbAddr;
    logic [31:0] wbData;

    int assertCount = 0;
    int failCount = 0;

    logic        obsEarly, obsBusy1, obsEn33, obsDone33, obsEn34, obsDone34, obsBusyEnd;
    logic [4:0]  obsAddr33, obsAddr34;
    logic [31:0] obsData33, obsData34;

    mul_wb_unit dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush),
        .opA(opA), .opB(opB), .destAddr(destAddr),
        .busy(busy), .done(done), .wbEn(wbEn), .wbAddr(wbAddr), .wbData(wbData)
    );

    always #5 clk = ~clk;

    // Launches one multiply and records what the unit shows in cycles 1..35 after acceptance.
    task automatic doMultiply(input logic [31:0] a, input logic [31:0] b, input logic [4:0] d);
        @(negedge clk);
        opA = a; opB = b; destAddr = d; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        obsBusy1 = busy;
        obsEarly = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            if (wbEn || done) obsEarly = 1'b1;
        end
        @(posedge clk); #1;
        obsEn33 = wbEn; obsAddr33 = wbAddr; obsData33 = wbData; obsDone33 = done;
        @(posedge clk); #1;
        obsEn34 = wbEn; obsAddr34 = wbAddr; obsData34 = wbData; obsDone34 = done;
        obsBusyEnd = busy;
        if (HI_EN) begin
            @(posedge clk); #1;
            obsBusyEnd = busy;
        end
    endtask

    task automatic test_reset();
        #3;
        assertCount++; if (busy !== 1'b0) begin failCount++; $display("FAIL reset_busy: got %b want 0", busy); end
        assertCount++; if (done !== 1'b0) begin failCount++; $display("FAIL reset_done: got %b want 0", done); end
        assertCount++; if (wbEn !== 1'b0) begin failCount++; $display("FAIL reset_wbEn: got %b want 0", wbEn); end
        assertCount++; if (wbAddr !== 5'd0) begin failCount++; $display("FAIL reset_wbAddr: got %0d want 0", wbAddr); end
        assertCount++; if (wbData !== 32'd0) begin failCount++; $display("FAIL reset_wbData: got %h want 0", wbData); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        doMultiply(32'd7, 32'd6, 5'd5);
        assertCount++; if (obsBusy1 !== 1'b1) begin failCount++; $display("FAIL basic_busy1: got %b want 1", obsBusy1); end
        assertCount++; if (obsEarly !== 1'b0) begin failCount++; $display("FAIL basic_early: got %b want 0", obsEarly); end
        assertCount++; if (obsEn33 !== 1'b1) begin failCount++; $display("FAIL basic_wbEn33: got %b want 1", obsEn33); end
        assertCount++; if (obsAddr33 !== 5'd5) begin failCount++; $display("FAIL basic_addr33: got %0d want 5", obsAddr33); end
        assertCount++; if (obsData33 !== 32'd42) begin failCount++; $display("FAIL basic_data33: got %h want 2a", obsData33); end
        assertCount++; if (obsDone33 !== !HI_EN) begin failCount++; $display("FAIL basic_done33: got %b want %b", obsDone33, !HI_EN); end
        assertCount++; if (obsEn34 !== HI_EN) begin failCount++; $display("FAIL basic_wbEn34: got %b want %b", obsEn34, HI_EN); end
        assertCount++; if (obsDone34 !== HI_EN) begin failCount++; $display("FAIL basic_done34: got %b want %b", obsDone34, HI_EN); end
        assertCount++; if (obsBusyEnd !== 1'b0) begin failCount++; $display("FAIL basic_busyEnd: got %b want 0", obsBusyEnd); end
    endtask

    task automatic test_negative();
        doMultiply(32'hFFFF_FFFD, 32'd5, 5'd8);
        assertCount++; if (obsEn33 !== 1'b1) begin failCount++; $display("FAIL neg_wbEn33: got %b want 1", obsEn33); end
        assertCount++; if (obsAddr33 !== 5'd8) begin failCount++; $display("FAIL neg_addr33: got %0d want 8", obsAddr33); end
        assertCount++; if (obsData33 !== 32'hFFFF_FFF1) begin failCount++; $display("FAIL neg_data33: got %h want fffffff1", obsData33); end
        assertCount++; if (obsAddr34 !== (HI_EN ? 5'd13 : 5'd8)) begin failCount++; $display("FAIL neg_addr34: got %0d want %0d", obsAddr34, HI_EN ? 13 : 8); end
        assertCount++; if (obsData34 !== (HI_EN ? 32'hFFFF_FFFF : 32'hFFFF_FFF1)) begin failCount++; $display("FAIL neg_data34: got %h", obsData34); end
    endtask

    task automatic test_min_operand();
        doMultiply(32'h8000_0000, 32'h8000_0000, 5'd9);
        assertCount++; if (obsEn33 !== 1'b1) begin failCount++; $display("FAIL min_wbEn33: got %b want 1", obsEn33); end
        assertCount++; if (obsAddr33 !== 5'd9) begin failCount++; $display("FAIL min_addr33: got %0d want 9", obsAddr33); end
        assertCount++; if (obsData33 !== 32'h0000_0000) begin failCount++; $display("FAIL min_data33: got %h want 0", obsData33); end
        assertCount++; if (obsData34 !== (HI_EN ? 32'h4000_0000 : 32'h0000_0000)) begin failCount++; $display("FAIL min_data34: got %h", obsData34); end
    endtask

    task automatic test_dest_zero();
        doMultiply(32'd2, 32'd3, 5'd0);
        assertCount++; if (obsEarly !== 1'b0) begin failCount++; $display("FAIL dz_early: got %b want 0", obsEarly); end
        assertCount++; if (obsEn33 !== 1'b0) begin failCount++; $display("FAIL dz_wbEn33: got %b want 0", obsEn33); end
        assertCount++; if (obsDone33 !== !HI_EN) begin failCount++; $display("FAIL dz_done33: got %b want %b", obsDone33, !HI_EN); end
        assertCount++; if (obsEn34 !== HI_EN) begin failCount++; $display("FAIL dz_wbEn34: got %b want %b", obsEn34, HI_EN); end
        assertCount++; if (obsDone34 !== HI_EN) begin failCount++; $display("FAIL dz_done34: got %b want %b", obsDone34, HI_EN); end
        assertCount++; if (obsBusyEnd !== 1'b0) begin failCount++; $display("FAIL dz_busyEnd: got %b want 0", obsBusyEnd); end
    endtask

    task automatic test_flush();
        logic sawWb;
        @(negedge clk);
        opA = 32'd9; opB = 32'd9; destAddr = 5'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 2; k <= 10; k++) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        assertCount++; if (busy !== 1'b0) begin failCount++; $display("FAIL flush_busy: got %b want 0", busy); end
        sawWb = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (wbEn || done) sawWb = 1'b1;
            @(posedge clk); #1;
        end
        assertCount++; if (sawWb !== 1'b0) begin failCount++; $display("FAIL flush_nowrite: got %b want 0", sawWb); end
        doMultiply(32'd4, 32'd4, 5'd3);
        assertCount++; if (obsEn33 !== 1'b1) begin failCount++; $display("FAIL flush_after_wbEn: got %b want 1", obsEn33); end
        assertCount++; if (obsData33 !== 32'd16) begin failCount++; $display("FAIL flush_after_data: got %h want 10", obsData33); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        opA = 32'd5; opB = 32'd5; destAddr = 5'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 2; k <= 5; k++) begin @(posedge clk); #1; end
        #2;
        rst = 1'b1;
        #1;
        assertCount++; if (busy !== 1'b0) begin failCount++; $display("FAIL arst_busy: got %b want 0", busy); end
        assertCount++; if (wbAddr !== 5'd0) begin failCount++; $display("FAIL arst_wbAddr: got %0d want 0", wbAddr); end
        assertCount++; if (wbData !== 32'd0) begin failCount++; $display("FAIL arst_wbData: got %h want 0", wbData); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_start_held();
        logic sawEarly;
        logic gotWb;
        @(negedge clk);
        opA = 32'd3; opB = 32'd7; destAddr = 5'd6; start = 1'b1;
        @(posedge clk); #1;
        opA = 32'd100; opB = 32'd100; destAddr = 5'd1;
        sawEarly = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            if (wbEn || done) sawEarly = 1'b1;
        end
        @(posedge clk); #1;
        assertCount++; if (sawEarly !== 1'b0) begin failCount++; $display("FAIL held_early: got %b want 0", sawEarly); end
        assertCount++; if (wbEn !== 1'b1) begin failCount++; $display("FAIL held_wbEn: got %b want 1", wbEn); end
        assertCount++; if (wbData !== 32'd21) begin failCount++; $display("FAIL held_data: got %h want 15", wbData); end
        assertCount++; if (wbAddr !== 5'd6) begin failCount++; $display("FAIL held_addr: got %0d want 6", wbAddr); end
        if (HI_EN) begin @(posedge clk); #1; end
        @(posedge clk); #1;
        assertCount++; if (busy !== 1'b0) begin failCount++; $display("FAIL held_idle: got %b want 0", busy); end
        @(posedge clk); #1;
        start = 1'b0;
        assertCount++; if (busy !== 1'b1) begin failCount++; $display("FAIL held_reaccept: got %b want 1", busy); end
        gotWb = 1'b0;
        for (int k = 0; k < 40 && !gotWb; k++) begin
            @(posedge clk); #1;
            if (wbEn) gotWb = 1'b1;
        end
        assertCount++; if (gotWb !== 1'b1) begin failCount++; $display("FAIL held_second_timeout: got %b want 1", gotWb); end
        assertCount++; if (wbData !== 32'd10000) begin failCount++; $display("FAIL held_second_data: got %0d want 10000", wbData); end
        assertCount++; if (wbAddr !== 5'd1) begin failCount++; $display("FAIL held_second_addr: got %0d want 1", wbAddr); end
        repeat (3) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_min_operand();
        test_dest_zero();
        test_flush();
        test_async_reset();
        test_start_held();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
